// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Definitions shared by the farm-road sensor conditioner and the
//   highway/farm light controllers it feeds.
//   - DEFAULT_CLK_HZ : default system clock, also the 1 s tick period
//   - farm_state_e   : farm-road request FSM states
//   - ST_*           : the same encodings as plain constants for legacy code
//   - light_e        : one-hot lamp encoding {red, yellow, green}
//   - seg7()         : hex digit to active-high a..g segment pattern
package traffic_pkg;

   localparam int DEFAULT_CLK_HZ = 50_000_000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAITING = 2'd1,
      SERVING = 2'd2
   } farm_state_e;

   // Plain constants with the same encoding as farm_state_e.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAITING = 2'd1;
   localparam logic [1:0] ST_SERVING = 2'd2;

   typedef enum logic [2:0] {
      LIGHT_RED    = 3'b100,
      LIGHT_YELLOW = 3'b010,
      LIGHT_GREEN  = 3'b001
   } light_e;

   // Segment order {g,f,e,d,c,b,a}, 1 = lit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      s = 7'h00;
      case (d)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/farm_sensor_conditioner_if.sv
// farm_sensor_conditioner_if
//   Signal bundle between the farm-road sensor conditioner and its
//   neighbours (loop sensor, light controller).
//   slave  : conditioner side -- takes c_raw/serve, drives everything else
//   master : environment side -- drives c_raw/serve, observes the rest
//   c_raw     raw loop sensor          serve     farm road is green
//   tick_1s   1 s strobe               c_clean   debounced sensor
//   car_pulse arrival strobe           car_count waiting vehicles
//   request   service request          wait_s    seconds waiting
//   urgent    wait limit reached
interface farm_sensor_conditioner_if #(
   parameter int CNT_W = 4
);
   logic             c_raw;
   logic             serve;
   logic             tick_1s;
   logic             c_clean;
   logic             car_pulse;
   logic [CNT_W-1:0] car_count;
   logic             request;
   logic [7:0]       wait_s;
   logic             urgent;

   modport master (
      output c_raw, serve,
      input  tick_1s, c_clean, car_pulse, car_count, request, wait_s, urgent
   );

   modport slave (
      input  c_raw, serve,
      output tick_1s, c_clean, car_pulse, car_count, request, wait_s, urgent
   );
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce
//   Two-flop synchroniser, debounce counter and rising-edge strobe for one
//   asynchronous level input.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   raw   in  asynchronous input level
//   clean out debounced level; follows raw DEB_CYC+2 edges after a stable step
//   rise  out one-cycle strobe, high in the first cycle clean reads 1
module sync_debounce #(
   parameter int DEB_CYC = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean,
   output logic rise
);

   localparam int            CW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // The counter only runs while the synchronised level disagrees with the
   // output; any agreeing cycle restarts the window, so a glitch shorter
   // than DEB_CYC cycles never reaches the terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= 1'b0;
         if (s2 == clean) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            clean <= s2;
            rise  <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/farm_sensor_conditioner.sv
// farm_sensor_conditioner
//   Conditions the farm-road vehicle loop for the light controllers: cleans
//   the sensor, counts waiting vehicles, holds a service request with a
//   seconds wait timer and urgency flag, and generates the shared 1 s tick.
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   bus   farm_sensor_conditioner_if.slave
//         in : c_raw, serve
//         out: tick_1s, c_clean, car_pulse, car_count, request, wait_s, urgent
module farm_sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int CLK_HZ      = DEFAULT_CLK_HZ,
   parameter int DEBOUNCE_MS = 10,
   parameter int CNT_W       = 4,
   parameter int MAX_WAIT_S  = 30
) (
   input logic                      clk,
   input logic                      rst,
   farm_sensor_conditioner_if.slave bus
);

   localparam int DEB_RAW = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int DEB_CYC = (DEB_RAW < 1) ? 1 : DEB_RAW;

   localparam int               TW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [TW-1:0]    TICK_LAST = TW'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [7:0]       WAIT_URG  = 8'(MAX_WAIT_S);

   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic             c_clean;
   logic             car_pulse;
   logic [1:0]       state;
   logic [CNT_W-1:0] car_count;
   logic [7:0]       wait_s;
   logic             request;

   // ---------------- 1 s tick, free running ----------------
   always_ff @(posedge clk) begin
      if (rst)                    tick_cnt <= '0;
      else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                        tick_cnt <= tick_cnt + TW'(1);
   end

   assign tick = (tick_cnt == TICK_LAST);

   // ---------------- sensor conditioning ----------------
   sync_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.c_raw),
      .clean (c_clean),
      .rise  (car_pulse)
   );

   // ---------------- request FSM ----------------
   // serve takes priority in WAITING: the green that clears the queue also
   // covers a vehicle arriving on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         car_count <= '0;
         wait_s    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (car_pulse) begin
                  state     <= ST_WAITING;
                  car_count <= CNT_ONE;
               end
            end
            ST_WAITING: begin
               if (bus.serve) begin
                  state     <= ST_SERVING;
                  car_count <= '0;
                  wait_s    <= '0;
               end else begin
                  if (car_pulse && car_count != CNT_MAX)
                     car_count <= car_count + CNT_ONE;
                  if (tick && wait_s != 8'hFF)
                     wait_s <= wait_s + 8'd1;
               end
            end
            ST_SERVING: begin
               // Arrivals during green drive straight through. When green
               // ends, a vehicle still sitting on the loop is a new request.
               if (!bus.serve) begin
                  if (c_clean) begin
                     state     <= ST_WAITING;
                     car_count <= CNT_ONE;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               car_count <= '0;
               wait_s    <= '0;
            end
         endcase
      end
   end

   assign request = (state == ST_WAITING);

   assign bus.tick_1s   = tick;
   assign bus.c_clean   = c_clean;
   assign bus.car_pulse = car_pulse;
   assign bus.car_count = car_count;
   assign bus.request   = request;
   assign bus.wait_s    = wait_s;
   assign bus.urgent    = request && (wait_s >= WAIT_URG);

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// tb_farm_sensor_conditioner
//   Bench for farm_sensor_conditioner with CLK_HZ=1000, DEBOUNCE_MS=5
//   (5-cycle debounce), CNT_W=2, MAX_WAIT_S=3. Each arrival driven pushes the
//   expected car_pulse cycle and the count/request that should follow; the
//   negedge monitor pops and compares when a pulse appears.
module tb_farm_sensor_conditioner;

   localparam int CLK_HZ = 1000;
   localparam int LAT    = 7;      // c_raw step to c_clean: DEB_CYC + 2 edges

   typedef struct {
      int   cyc;
      int   cnt;
      logic req;
   } sb_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   int   ticks;
   sb_t  sb_q[$];
   logic pend;
   int   pend_cnt;
   logic pend_req;

   farm_sensor_conditioner_if #(.CNT_W(2)) bus ();

   farm_sensor_conditioner #(
      .CLK_HZ      (CLK_HZ),
      .DEBOUNCE_MS (5),
      .CNT_W       (2),
      .MAX_WAIT_S  (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since the last reset edge; equals the DUT tick phase.
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for tick_1s, then lands #1 after the following edge.
   task automatic wait_tick(output int at);
      bit seen;
      seen = 1'b0;
      at   = -1;
      for (int k = 0; k < 1100 && !seen; k++) begin
         @(negedge clk);
         if (bus.tick_1s) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      chk("tick_seen", 32'(seen), 1);
      step(1);
   endtask

   task automatic arrive(input int exp_cnt, input logic exp_req);
      bus.c_raw = 1'b0;
      step(10);
      bus.c_raw = 1'b1;
      sb_q.push_back('{cyc: cyc + LAT, cnt: exp_cnt, req: exp_req});
      step(10);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin : mon
      sb_t  e;
      logic exp_tick;
      if (!rst) begin
         if (pend) begin
            chk("cnt_after_pulse", 32'(bus.car_count), pend_cnt);
            chk("req_after_pulse", 32'(bus.request), 32'(pend_req));
            pend = 1'b0;
         end
         if (bus.car_pulse) begin
            chk("pulse_clean", 32'(bus.c_clean), 1);
            if (sb_q.size() == 0) begin
               chk("pulse_unexpected", 1, 0);
            end else begin
               e = sb_q.pop_front();
               chk("pulse_cyc", cyc, e.cyc);
               pend     = 1'b1;
               pend_cnt = e.cnt;
               pend_req = e.req;
            end
         end
         exp_tick = (cyc % CLK_HZ == CLK_HZ - 1);
         if (bus.tick_1s || exp_tick) chk("tick", 32'(bus.tick_1s), 32'(exp_tick));
         if (bus.tick_1s) ticks++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic acc;
      int   at;
      checks    = 0;
      errors    = 0;
      ticks     = 0;
      pend      = 1'b0;
      rst       = 1'b1;
      bus.c_raw = 1'b0;
      bus.serve = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tick",    32'(bus.tick_1s),   0);
      chk("rst_clean",   32'(bus.c_clean),   0);
      chk("rst_pulse",   32'(bus.car_pulse), 0);
      chk("rst_count",   32'(bus.car_count), 0);
      chk("rst_request", 32'(bus.request),   0);
      chk("rst_wait",    32'(bus.wait_s),    0);
      chk("rst_urgent",  32'(bus.urgent),    0);
      step(1);
      rst = 1'b0;

      // Idle: only the tick should move.
      acc = 1'b0;
      repeat (2500) begin
         @(negedge clk);
         acc |= bus.c_clean | bus.car_pulse | bus.request | bus.urgent |
                (bus.car_count != 0) | (bus.wait_s != 0);
      end
      chk("idle_quiet", 32'(acc), 0);
      chk("idle_ticks", ticks, 2);

      // serve while IDLE has no effect.
      step(1);
      bus.serve = 1'b1;
      step(5);
      chk("idle_serve_req", 32'(bus.request),   0);
      chk("idle_serve_cnt", 32'(bus.car_count), 0);
      bus.serve = 1'b0;
      step(2);

      // 4-cycle glitch is filtered.
      bus.c_raw = 1'b1;
      step(4);
      bus.c_raw = 1'b0;
      acc = 1'b0;
      repeat (15) begin
         @(negedge clk);
         acc |= bus.c_clean | bus.car_pulse | bus.request;
      end
      chk("glitch_filtered", 32'(acc), 0);
      step(1);

      // First arrival, then four more: count saturates at 3.
      arrive(1, 1'b1);
      chk("clean_hi", 32'(bus.c_clean), 1);
      arrive(2, 1'b1);
      arrive(3, 1'b1);
      arrive(3, 1'b1);
      arrive(3, 1'b1);
      chk("sat_count", 32'(bus.car_count), 3);
      chk("wait_pre",  32'(bus.wait_s),    0);

      wait_tick(at);
      chk("wait_1", 32'(bus.wait_s), 1);
      chk("urg_1",  32'(bus.urgent), 0);
      wait_tick(at);
      chk("wait_2", 32'(bus.wait_s), 2);
      chk("urg_2",  32'(bus.urgent), 0);
      wait_tick(at);
      chk("wait_3", 32'(bus.wait_s), 3);
      chk("urg_3",  32'(bus.urgent), 1);
      chk("req_3",  32'(bus.request), 1);

      // serve lands on the same edge as a car_pulse: serve wins.
      bus.c_raw = 1'b0;
      step(10);
      bus.c_raw = 1'b1;
      sb_q.push_back('{cyc: cyc + LAT, cnt: 0, req: 1'b0});
      step(LAT);
      bus.serve = 1'b1;
      step(1);
      chk("srv_req",    32'(bus.request),   0);
      chk("srv_count",  32'(bus.car_count), 0);
      chk("srv_wait",   32'(bus.wait_s),    0);
      chk("srv_urgent", 32'(bus.urgent),    0);
      step(5);
      chk("srv_hold_req", 32'(bus.request), 0);
      bus.serve = 1'b0;
      step(1);
      chk("resume_req",   32'(bus.request),   1);
      chk("resume_count", 32'(bus.car_count), 1);
      chk("resume_wait",  32'(bus.wait_s),    0);

      // Reset mid-WAITING with wait_s == 2.
      wait_tick(at);
      wait_tick(at);
      chk("pre_rst_wait", 32'(bus.wait_s), 2);
      rst       = 1'b1;
      bus.c_raw = 1'b0;
      step(1);
      chk("mid_rst_req",   32'(bus.request),   0);
      chk("mid_rst_count", 32'(bus.car_count), 0);
      chk("mid_rst_wait",  32'(bus.wait_s),    0);
      chk("mid_rst_clean", 32'(bus.c_clean),   0);
      chk("mid_rst_tick",  32'(bus.tick_1s),   0);
      rst = 1'b0;
      wait_tick(at);
      chk("tick_after_rst", at, CLK_HZ - 1);
      chk("post_rst_req",   32'(bus.request), 0);

      chk("sb_drain", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
